rf_write_arbiter: RTL and testbench

- Owns the single register-file write port, which is shared by two requesters: the in-order WB stage and a long-latency unit (LLU), i.e. multi-cycle mul/div or a load-miss return.
- WB always has priority. LLU results that lose arbitration are held in an in-order FIFO and drained into idle WB slots.
- Holds a per-register scoreboard of LLU-pending destinations so that decode can stall on RAW/WAW hazards against outstanding LLU results.
- Sits between WB/LLU and the register file's we/wreg/wdata inputs in the decode stage.

---
 rtl/rf_write_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, LLU results queue in an
// in-order FIFO and drain into idle WB slots; tracks LLU-pending destinations.
module rf_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_wb_we,
  input  logic [4:0]               in_wb_rd,
  input  logic [31:0]              in_wb_data,
  input  logic                     in_llu_valid,
  input  logic [4:0]               in_llu_rd,
  input  logic [31:0]              in_llu_data,
  output logic                     out_llu_ready,
  input  logic                     in_issue_valid,
  input  logic [4:0]               in_issue_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  output logic                     out_rf_we,
  output logic [4:0]               out_rf_wreg,
  output logic [31:0]              out_rf_wdata,
  output logic                     out_raw_stall,
  output logic                     out_pipe_stall,
  output logic [$clog2(DEPTH):0]   out_fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   busy, busy_nxt;
  logic [SW-1:0] starve;

  logic        wb_req, fifo_empty, llu_xfer, pop, bypass, push;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  always_comb begin
    wb_req        = in_wb_we && (in_wb_rd != '0);
    fifo_empty    = (count == '0);
    out_llu_ready = (count < FULL);
    llu_xfer      = in_llu_valid && out_llu_ready;
    pop           = !wb_req && !fifo_empty;
    bypass        = !wb_req && fifo_empty && llu_xfer;
    push          = llu_xfer && !bypass;
    head_rd       = mem_rd[head];
    head_data     = mem_data[head];

    out_rf_we    = 1'b0;
    out_rf_wreg  = '0;
    out_rf_wdata = '0;
    // Outputs are forced idle while reset is held, not just after the edge.
    if (!reset) begin
      if (wb_req) begin
        out_rf_we    = 1'b1;
        out_rf_wreg  = in_wb_rd;
        out_rf_wdata = in_wb_data;
      end else if (pop) begin
        if (head_rd != '0) begin
          out_rf_we    = 1'b1;
          out_rf_wreg  = head_rd;
          out_rf_wdata = head_data;
        end
      end else if (bypass && in_llu_rd != '0) begin
        out_rf_we    = 1'b1;
        out_rf_wreg  = in_llu_rd;
        out_rf_wdata = in_llu_data;
      end
    end

    out_raw_stall  = busy[in_rs1] | busy[in_rs2] | busy[in_rd];
    out_pipe_stall = (starve == STARVE_MX);
    out_fifo_count = count;

    // Clears applied before the set so a same-cycle issue keeps the bit.
    busy_nxt = busy;
    if (pop && head_rd != '0)          busy_nxt[head_rd]   = 1'b0;
    if (bypass && in_llu_rd != '0)     busy_nxt[in_llu_rd] = 1'b0;
    if (in_issue_valid && in_issue_rd != '0) busy_nxt[in_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[tail]   <= in_llu_rd;
      mem_data[tail] <= in_llu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      busy   <= '0;
      starve <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      busy <= busy_nxt;
      if (pop)
        starve <= '0;
      else if (!fifo_empty && wb_req && starve != STARVE_MX)
        starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a queue-based
// reference model of the write-port, scoreboard and starvation rules.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we, llu_valid, issue_valid;
  logic [4:0]  wb_rd, llu_rd, issue_rd, rs1, rs2, rd;
  logic [31:0] wb_data, llu_data;
  logic        llu_ready, rf_we, raw_stall, pipe_stall;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .in_wb_we(wb_we), .in_wb_rd(wb_rd), .in_wb_data(wb_data),
    .in_llu_valid(llu_valid), .in_llu_rd(llu_rd), .in_llu_data(llu_data),
    .out_llu_ready(llu_ready),
    .in_issue_valid(issue_valid), .in_issue_rd(issue_rd),
    .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
    .out_rf_we(rf_we), .out_rf_wreg(rf_wreg), .out_rf_wdata(rf_wdata),
    .out_raw_stall(raw_stall), .out_pipe_stall(pipe_stall),
    .out_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t     q[$];
  bit [31:0] m_busy;
  int       m_starve;
  bit       m_pop, m_byp, m_push;
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then check
  // every output against the model's prediction for this cycle.
  task automatic drive(input bit we, input bit [4:0] wrd, input bit [31:0] wd,
                       input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                       input bit iv, input bit [4:0] ird,
                       input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] d);
    bit wbreq, xfer, e_we, e_ready;
    bit [4:0] e_reg;
    bit [31:0] e_data;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    llu_valid = lv; llu_rd = lrd; llu_data = ld;
    issue_valid = iv; issue_rd = ird;
    rs1 = s1; rs2 = s2; rd = d;
    #1;
    e_ready = q.size() < DEPTH;
    wbreq   = we && wrd != 0;
    xfer    = lv && e_ready;
    e_we = 0; e_reg = 0; e_data = 0;
    if (wbreq) begin
      e_we = 1; e_reg = wrd; e_data = wd;
    end else if (q.size() > 0) begin
      e_we = q[0].rd != 0; e_reg = q[0].rd; e_data = q[0].data;
    end else if (xfer) begin
      e_we = lrd != 0; e_reg = lrd; e_data = ld;
    end
    m_pop  = !wbreq && q.size() > 0;
    m_byp  = !wbreq && q.size() == 0 && xfer;
    m_push = xfer && !m_byp;
    check("llu_ready", llu_ready, e_ready);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_wreg", rf_wreg, e_reg);
      check("rf_wdata", rf_wdata, e_data);
    end
    check("raw_stall", raw_stall, m_busy[s1] | m_busy[s2] | m_busy[d]);
    check("pipe_stall", pipe_stall, m_starve == LIMIT);
    check("fifo_count", fifo_count, q.size());
  endtask

  // Apply the clock-edge effects of the driven cycle to the model.
  task automatic advance();
    bit wbreq = wb_we && wb_rd != 0;
    if (m_pop) begin
      m_starve = 0;
    end else if (q.size() > 0 && wbreq) begin
      m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    end
    if (m_pop) begin
      if (q[0].rd != 0) m_busy[q[0].rd] = 0;
      void'(q.pop_front());
    end
    if (m_byp && llu_rd != 0) m_busy[llu_rd] = 0;
    if (m_push) q.push_back('{rd: llu_rd, data: llu_data});
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    m_busy[0] = 0;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    llu_valid = 0; llu_rd = 0; llu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; rd = 0;
    q = {}; m_busy = 0; m_starve = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", rf_we, 0);
    check("rst_ready", llu_ready, 1);
    check("rst_pstall", pipe_stall, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Bypass into an idle WB slot
    drive(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check("byp_we", rf_we, 1);
    check("byp_wreg", rf_wreg, 5);
    check("byp_wdata", rf_wdata, 32'hDEAD_BEEF);
    advance();
    idle();
    check("byp_count", fifo_count, 0);
    advance();

    // WB wins, LLU result drains next cycle
    drive(1, 3, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0, 0);
    check("wbpri_wreg", rf_wreg, 3);
    advance();
    idle();
    check("drain_wreg", rf_wreg, 7);
    check("drain_count", fifo_count, 1);
    advance();
    idle();
    check("drain_empty", fifo_count, 0);
    advance();

    // Fill the FIFO under WB pressure, hold off a 5th, then drain in order
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, i, 1, 5'(10 + i), 32'h100 + i, 0, 0, 0, 0, 0);
      advance();
    end
    check("full_count", fifo_count, 4);
    check("full_ready", llu_ready, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 5'd20, 32'h200 + i, 0, 0, 0, 0, 0);
      if (i < 4) check("order_wreg", rf_wreg, 10 + i);
      advance();
    end
    for (int i = 0; i < 6; i++) begin idle(); advance(); end

    // Scoreboard: issue x9, stall until its write, same-cycle set wins
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    check("raw_set", raw_stall, 1);
    advance();
    drive(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    check("raw_clr", raw_stall, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0); advance();
    drive(0, 0, 0, 1, 9, 32'h98, 1, 9, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    check("raw_setwins", raw_stall, 1);
    advance();
    drive(0, 0, 0, 1, 9, 32'h97, 0, 0, 0, 0, 0); advance();

    // Starvation: one queued entry, WB held 8 cycles
    drive(1, 2, 32'h5, 1, 12, 32'hC, 0, 0, 0, 0, 0); advance();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1, 2, i, 0, 0, 0, 0, 0, 0, 0, 0); advance();
    end
    drive(1, 2, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_on", pipe_stall, 1);
    advance();
    idle();
    check("starve_pop", rf_wreg, 12);
    advance();
    idle();
    check("starve_off", pipe_stall, 0);
    advance();

    // Asynchronous reset with 3 entries queued and busy bits set
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 5'(4 + i), i, 1, 5'(4 + i), 0, 0, 0); advance();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 4, 5, 6);
    check("pre_rst_count", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    check("arst_count", fifo_count, 0);
    check("arst_we", rf_we, 0);
    check("arst_ready", llu_ready, 1);
    check("arst_raw", raw_stall, 0);
    q = {}; m_busy = 0; m_starve = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized traffic with bursty WB phases to exercise starvation
    begin
      int unsigned wb_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 64 == 0) wb_pct = $urandom_range(0, 3) == 0 ? 100 : $urandom_range(10, 90);
        drive($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        advance();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
